// File: rtl/isquare_pkg.sv
// rtl/isquare_pkg.sv - shared widths and types for the iterative squarer and square-root blocks
//
// Purpose: operand/result widths and typedefs shared by isquare16, the
// square-root block and benches.

package isquare_pkg;

  localparam int YW = 16;  // root width
  localparam int RW = 17;  // remainder width
  localparam int XW = 32;  // radicand / result width
  localparam int AW = 33;  // accumulator width (result plus carry-out)
  localparam int CW = 5;   // step index width

  typedef logic [YW-1:0] y_t;
  typedef logic [RW-1:0] r_t;
  typedef logic [XW-1:0] x_t;
  typedef logic [AW-1:0] acc_t;
  typedef logic [CW-1:0] cnt_t;

  // Index of the final step of an operation.
  localparam cnt_t LAST_STEP = cnt_t'(YW - 1);

endpackage

// File: rtl/isquare16.sv
// rtl/isquare16.sv - iterative 16-bit squarer with remainder add, x = y*y + r
//
// Purpose: rebuilds a radicand from a (root, remainder) pair using one
// shift-add step per clock, 16 steps per operation.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   sample y/r and begin an operation (ignored while busy)
//   y      in   16-bit unsigned root
//   r      in   17-bit unsigned remainder
//   busy   out  operation in progress
//   rdy    out  result valid; x/ovf hold until the next accepted start
//   x      out  low 32 bits of y*y + r
//   ovf    out  y*y + r >= 2^32

module isquare16
  import isquare_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [YW-1:0] y,
  input  logic [RW-1:0] r,
  output logic          busy,
  output logic          rdy,
  output logic [XW-1:0] x,
  output logic          ovf
);

  y_t   yreg_q, yreg_d;
  acc_t acc_q,  acc_d;
  cnt_t cnt_q,  cnt_d;
  logic busy_q, busy_d;
  logic rdy_q,  rdy_d;

  // Partial product for the current bit; the 33-bit width keeps the carry
  // so the 2^32 overflow case is represented exactly.
  acc_t addend;

  always_comb begin
    yreg_d = yreg_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    rdy_d  = rdy_q;
    addend = acc_t'(yreg_q) << cnt_q;

    if (!busy_q) begin
      // Idle (with or without a held result): a start is accepted and
      // clears any pending rdy on the same edge.
      if (start) begin
        yreg_d = y;
        acc_d  = acc_t'(r);
        cnt_d  = '0;
        busy_d = 1'b1;
        rdy_d  = 1'b0;
      end
    end else begin
      if (yreg_q[cnt_q[3:0]]) begin
        acc_d = acc_q + addend;
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
        rdy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      yreg_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      yreg_q <= yreg_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      rdy_q  <= rdy_d;
    end
  end

  assign busy = busy_q;
  assign rdy  = rdy_q;
  assign x    = acc_q[XW-1:0];
  assign ovf  = acc_q[AW-1];

endmodule

// File: doc/isquare16.md
# isquare16

Iterative 16-bit squarer with remainder add: computes x = y*y + r, one shift-add step per clock, 16 steps per operation. It is the inverse of the team's iterative square-root block, so it rebuilds the radicand from a (root, remainder) pair. Intended uses are self-checking of square-root results in the datapath and rebuilding the radicand in downstream arithmetic.

## Interface
- Parameters: none. All widths are fixed and come from the shared package.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request: sample y and r and begin an operation.
- y  input  16  root operand, unsigned.
- r  input  17  remainder operand, unsigned, nominally ≤ 2*y.
- busy  output  1  operation in progress.
- rdy  output  1  result valid.
- x  output  32  result, low 32 bits of y*y + r.
- ovf  output  1  y*y + r ≥ 2^32.

## Operation
- State:
  - yreg: 16 bits, latched y.
  - acc: 33 bits, accumulator.
  - cnt: 5 bits, step index.
  - flags: busy and rdy.
- Idle means busy=0. In this state, start=1 does the following on the edge:
  - yreg←y.
  - acc←zero-extended r.
  - cnt←0.
  - busy←1 and rdy←0.
- Step, when busy=1. Each edge:
  - If yreg[cnt]=1, acc←acc + (yreg << cnt), with 33-bit add and no truncation.
  - cnt←cnt+1.
- Completion: on the step edge where cnt=15:
  - busy←0 and rdy←1.
  - x and ovf are driven combinationally from acc[31:0] and acc[32].
- x and ovf are valid only while rdy=1. They hold until the next accepted start.
- start while busy=1 is ignored. Inputs are not sampled and the operation is unaffected.
- start while rdy=1 is accepted. rdy drops on that edge.
- Arithmetic:
  - Max result: 65535² + 131071 = 2^32, which gives x=0 and ovf=1.
  - r > 2*y is legal and gives the exact sum, flagged by ovf if it exceeds 32 bits.
- Reset has priority over start and over any step:
  - acc=0, yreg=0, cnt=0.
  - busy=0, rdy=0.
  - Therefore x=0 and ovf=0.
- Reset mid-operation aborts the operation; no rdy pulse follows.

## Timing
- Start accepted at edge E0. Step edges are E1 to E16. busy=1 from after E0 until E16. rdy=1 from after E16.
- Latency is 16 cycles from accepting start to rdy.
- Throughput: one operation per 17 cycles when start is reasserted on the first rdy cycle.
- start and reset arriving on the same edge: reset wins, and the block stays idle with rdy=0.
- Outputs are registered, or are direct slices of registered state, with no combinational path from inputs to outputs.
- rdy and busy are never both 1.

## Structure
- Shared package isquare_pkg holds:
  - YW=16, RW=17, XW=32, AW=33, CW=5.
  - The typedefs y_t, r_t, x_t, acc_t.
  - The package is also importable by the square-root block and by benches.
- A single module with no sub-module is sufficient. The step adder is inlined.
- The bench reference model lives in the bench, not in RTL.

## Test plan
- Reset, then idle, no start → busy=0, rdy=0, x=0, ovf=0 held for 20 cycles.
- y=0, r=0 → rdy after 16 cycles, x=0, ovf=0. Then y=1234, r=5 → x=1522761 (0x00173C49).
- y=65535, r=131070 → x=0xFFFFFFFF, ovf=0. Then y=65535, r=131071 → x=0x00000000, ovf=1.
- Pulse start with y=3, r=0 at E0. Pulse start with y=7, r=0 at E5 → second request ignored. At E16 → x=9. Then start on the first rdy cycle with y=7 → rdy drops next cycle, x=49 after 16 more.
- Reset at E8 of an operation with y=100 → busy=0 and rdy=0 next cycle, no rdy pulse. A start held on the reset edge is not accepted.
- Randomized back-to-back operations over y∈[0,65535] and r∈[0,131071] → {ovf,x} equals y*y + r for every result, and latency is exactly 16 cycles.
